conv_output_streamer: RTL and testbench

//  AXI4-Stream master transmitter at the output end of the Conv2D 3x3 datapath.

---
 rtl/conv_output_streamer_pkg.sv | 19 +
 rtl/conv_output_streamer_sync_fifo.sv | 59 +++++
 rtl/conv_output_streamer.sv | 156 +++++++++++++++
 tb/tb_conv_output_streamer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_output_streamer_pkg.sv
// conv_output_streamer_pkg
//   Shared defaults for the Conv2D output streamer: word and accumulator widths,
//   requantization shift, FIFO depth and the frame length derived from the output
//   tensor shape (H_out * W_out * K).
package conv_output_streamer_pkg;

    function automatic int unsigned frame_len(input int unsigned h_out,
                                              input int unsigned w_out,
                                              input int unsigned k);
        return h_out * w_out * k;
    endfunction

    localparam int unsigned DefWidth     = 16;
    localparam int unsigned DefAccWidth  = 40;
    localparam int unsigned DefShift     = 8;
    localparam int unsigned DefFifoDepth = 16;
    localparam int unsigned DefFrameLen  = frame_len(16, 16, 16);

endpackage

// File: rtl/conv_output_streamer_sync_fifo.sv
// conv_output_streamer_sync_fifo
//   Synchronous FIFO holding {tlast, data} words for the output streamer.
//   The head word is presented combinationally on o_pop_data; the consumer's own
//   register is the read stage. Push and pop in the same cycle leave the count
//   unchanged. The consumer never pushes when full or pops when empty.
// Ports
//   i_aclk       clock
//   i_aresetn    synchronous active-low reset (pointers and count)
//   i_push       write i_push_data at the tail
//   i_push_data  word to write
//   i_pop        drop the head word
//   o_pop_data   current head word
//   o_count      number of words held, 0..DEPTH
module conv_output_streamer_sync_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_aclk,
    input  logic                     i_aresetn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;

    always_ff @(posedge i_aclk) begin
        if (i_push) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (i_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (i_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case ({i_push, i_pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_pop_data = mem_q[rd_ptr_q];
    assign o_count    = count_q;

endmodule

// File: rtl/conv_output_streamer.sv
// conv_output_streamer
//   AXI4-Stream master at the output of the Conv2D 3x3 datapath. Each accumulator
//   result is requantized (round half up, arithmetic shift, saturate to WIDTH bits),
//   buffered in a FIFO and streamed with o_tlast on the last word of each frame.
// Ports
//   i_aclk, i_aresetn        clock, synchronous active-low reset
//   i_res_valid/o_res_ready  accumulator result handshake (ready is credit based)
//   i_res_data               signed accumulator result, ACC_WIDTH bits
//   o_tvalid/i_tready        AXI4-Stream handshake
//   o_tdata, o_tlast         requantized word and end-of-frame flag
//   o_frame_done             one-cycle pulse after the o_tlast handshake
//   o_busy                   any word held in the requant stage, FIFO or output register
module conv_output_streamer
    import conv_output_streamer_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned ACC_WIDTH  = DefAccWidth,
    parameter int unsigned SHIFT      = DefShift,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth,
    parameter int unsigned FRAME_LEN  = DefFrameLen
) (
    input  logic                 i_aclk,
    input  logic                 i_aresetn,
    input  logic                 i_res_valid,
    output logic                 o_res_ready,
    input  logic [ACC_WIDTH-1:0] i_res_data,
    output logic                 o_tvalid,
    input  logic                 i_tready,
    output logic [WIDTH-1:0]     o_tdata,
    output logic                 o_tlast,
    output logic                 o_frame_done,
    output logic                 o_busy
);

    localparam int unsigned SumW   = ACC_WIDTH + 1;
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FrameW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic signed [SumW-1:0] RoundK = SumW'(1) << (SHIFT - 1);
    localparam logic signed [SumW-1:0] SatMax =
        {{(SumW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [SumW-1:0] SatMin =
        {{(SumW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    // Requantization; one extra bit keeps the rounding add from overflowing.
    logic signed [SumW-1:0] sum, shifted;
    logic [WIDTH-1:0]       requant;

    always_comb begin
        sum     = $signed({i_res_data[ACC_WIDTH-1], i_res_data}) + RoundK;
        shifted = sum >>> SHIFT;
        if (shifted > SatMax) begin
            requant = SatMax[WIDTH-1:0];
        end else if (shifted < SatMin) begin
            requant = SatMin[WIDTH-1:0];
        end else begin
            requant = shifted[WIDTH-1:0];
        end
    end

    logic accept;
    assign accept = i_res_valid & o_res_ready;

    logic             stage_valid_q;
    logic [WIDTH-1:0] stage_data_q;

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
        end else begin
            stage_valid_q <= accept;
            if (accept) stage_data_q <= requant;
        end
    end

    // Frame position is tagged as words enter the FIFO; order is preserved all the
    // way to the output, so this matches the handshake count.
    logic [FrameW-1:0] word_idx_q;
    logic              word_last;
    assign word_last = (word_idx_q == FrameW'(FRAME_LEN - 1));

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            word_idx_q <= '0;
        end else if (stage_valid_q) begin
            word_idx_q <= word_last ? '0 : word_idx_q + FrameW'(1);
        end
    end

    logic             fifo_pop;
    logic [WIDTH:0]   fifo_rd_data;
    logic [CntW-1:0]  fifo_count;

    conv_output_streamer_sync_fifo #(
        .WIDTH(WIDTH + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_aclk      (i_aclk),
        .i_aresetn   (i_aresetn),
        .i_push      (stage_valid_q),
        .i_push_data ({word_last, stage_data_q}),
        .i_pop       (fifo_pop),
        .o_pop_data  (fifo_rd_data),
        .o_count     (fifo_count)
    );

    logic             tvalid_q, tlast_q, frame_done_q, res_ready_q;
    logic [WIDTH-1:0] tdata_q;

    assign fifo_pop = (!tvalid_q || i_tready) && (fifo_count != '0);

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= tvalid_q & i_tready & tlast_q;
            if (fifo_pop) begin
                tvalid_q <= 1'b1;
                tdata_q  <= fifo_rd_data[WIDTH-1:0];
                tlast_q  <= fifo_rd_data[WIDTH];
            end else if (i_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    // Credit: words that will sit in FIFO + stage after this edge, counting the
    // result accepted now. Keeping that below FIFO_DEPTH means the stage never
    // finds the FIFO full even though ready is registered.
    logic [CntW:0] held_next;

    always_comb begin
        held_next = {1'b0, fifo_count} + (CntW + 1)'(stage_valid_q) + (CntW + 1)'(accept)
                    - (CntW + 1)'(fifo_pop);
    end

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            res_ready_q <= 1'b0;
        end else begin
            res_ready_q <= held_next < (CntW + 1)'(FIFO_DEPTH);
        end
    end

    assign o_res_ready  = res_ready_q;
    assign o_tvalid     = tvalid_q;
    assign o_tdata      = tdata_q;
    assign o_tlast      = tlast_q;
    assign o_frame_done = frame_done_q;
    assign o_busy       = stage_valid_q | (fifo_count != '0) | tvalid_q;

endmodule

// File: tb/tb_conv_output_streamer.sv
module tb_conv_output_streamer;

    localparam int FL = 5;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [39:0] res_data = '0;
    logic        tvalid;
    logic        tready = 1'b1;
    logic [15:0] tdata;
    logic        tlast;
    logic        frame_done;
    logic        busy;

    conv_output_streamer #(
        .WIDTH     (16),
        .ACC_WIDTH (40),
        .SHIFT     (8),
        .FIFO_DEPTH(16),
        .FRAME_LEN (FL)
    ) dut (
        .i_aclk      (aclk),
        .i_aresetn   (aresetn),
        .i_res_valid (res_valid),
        .o_res_ready (res_ready),
        .i_res_data  (res_data),
        .o_tvalid    (tvalid),
        .i_tready    (tready),
        .o_tdata     (tdata),
        .o_tlast     (tlast),
        .o_frame_done(frame_done),
        .o_busy      (busy)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Specification-level requantization: floor((x + 128) / 256), clamped to int16.
    function automatic logic [15:0] model_requant(input logic [39:0] x);
        longint v;
        v = longint'($signed(x));
        v = (v + 128) >>> 8;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    typedef struct {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] obs_d[$];
    logic        obs_l[$];
    int          widx = 0;
    logic        exp_fd = 1'b0;
    logic        stall_prev = 1'b0;
    int          fd_count = 0;
    logic        rst_edge = 1'b1;

    always @(posedge aclk) rst_edge <= !aresetn;

    // Compare process: outputs checked against the model every cycle, model advanced
    // with the handshakes that will happen at the coming edge.
    always @(negedge aclk) begin
        exp_t e;
        if (rst_edge) begin
            chk("rst_tvalid", tvalid, 0);
            chk("rst_tdata", tdata, 0);
            chk("rst_tlast", tlast, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_res_ready", res_ready, 0);
            exp_q.delete();
            widx = 0;
            exp_fd = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("frame_done", frame_done, exp_fd);
            chk("busy", busy, exp_q.size() != 0);
            if (frame_done) fd_count++;
            if (stall_prev) chk("stall_hold_tvalid", tvalid, 1);
            if (tvalid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_tvalid", tvalid, 0);
                end else begin
                    chk("tdata", tdata, exp_q[0].d);
                    chk("tlast", tlast, exp_q[0].l);
                end
            end
            exp_fd = 1'b0;
            stall_prev = 1'b0;
            if (aresetn) begin
                if (tvalid && tready && exp_q.size() != 0) begin
                    exp_fd = exp_q[0].l;
                    obs_d.push_back(tdata);
                    obs_l.push_back(tlast);
                    void'(exp_q.pop_front());
                end
                stall_prev = tvalid && !tready;
                if (res_valid && res_ready) begin
                    e.d = model_requant(res_data);
                    e.l = (widx == FL - 1);
                    widx = (widx == FL - 1) ? 0 : widx + 1;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        res_valid = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic push_word(input logic [39:0] x);
        logic got;
        int   n;
        res_valid = 1'b1;
        res_data = x;
        got = 1'b0;
        n = 0;
        while (!got && n < 300) begin
            @(negedge aclk);
            got = res_ready;
            @(posedge aclk);
            #1;
            n++;
        end
        if (!got) chk("push_timeout", got, 1);
        res_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        tready = 1'b1;
        res_valid = 1'b0;
        n = 0;
        @(negedge aclk);
        while (busy && n < 400) begin
            @(negedge aclk);
            n++;
        end
        chk("drain_idle", busy, 0);
        step();
    endtask

    task automatic chk_obs(input string nm, input int i, input logic [15:0] d, input logic l);
        if (i < obs_d.size()) begin
            chk($sformatf("%s_data[%0d]", nm, i), obs_d[i], d);
            chk($sformatf("%s_last[%0d]", nm, i), obs_l[i], l);
        end else begin
            chk($sformatf("%s_missing[%0d]", nm, i), obs_d.size(), i + 1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] x;
        logic [31:0] r32;
        int          acc, cyc, sent, fd0, si;
        logic        nxt;

        // 1: reset values, latency, basic rounding (frame words 0,1,2)
        do_reset(2);
        @(negedge aclk);
        chk("t1_ready_in_reset", res_ready, 0);
        @(negedge aclk);
        chk("t1_ready_after", res_ready, 1);
        chk("t1_tvalid_after", tvalid, 0);
        step();
        obs_d.delete(); obs_l.delete();
        push_word(40'h100);
        @(negedge aclk);
        chk("t1_lat_n", tvalid, 0);
        @(negedge aclk);
        chk("t1_lat_n1", tvalid, 0);
        @(negedge aclk);
        chk("t1_lat_n2", tvalid, 1);
        step();
        push_word(40'h180);
        push_word(-40'sh180);
        drain();
        chk("t1_count", obs_d.size(), 3);
        chk_obs("t1", 0, 16'h0001, 1'b0);
        chk_obs("t1", 1, 16'h0002, 1'b0);
        chk_obs("t1", 2, 16'hFFFF, 1'b0);

        // 2: saturation (frame words 3,4,0)
        obs_d.delete(); obs_l.delete();
        push_word(40'sd1073741824);
        push_word(-40'sd1073741824);
        push_word(40'h7FFF7F);
        drain();
        chk("t2_count", obs_d.size(), 3);
        chk_obs("t2", 0, 16'h7FFF, 1'b0);
        chk_obs("t2", 1, 16'h8000, 1'b1);
        chk_obs("t2", 2, 16'h7FFF, 1'b0);

        // 3: backpressure, 17 results fit (16 FIFO + output register)
        obs_d.delete(); obs_l.delete();
        tready = 1'b0;
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            res_valid = (acc < 20);
            res_data = 40'(100 + acc) << 8;
            @(negedge aclk);
            if (res_valid && res_ready) acc++;
            @(posedge aclk);
            #1;
        end
        chk("t3_accepted", acc, 17);
        chk("t3_ready_low", res_ready, 0);
        chk("t3_tvalid_held", tvalid, 1);
        chk("t3_tdata_held", tdata, 16'd100);
        tready = 1'b1;
        while (acc < 20) begin
            push_word(40'(100 + acc) << 8);
            acc++;
        end
        drain();
        chk("t3_count", obs_d.size(), 20);
        for (int i = 0; i < 20; i++) chk_obs("t3", i, 16'(100 + i), (i % FL) == 3);

        // 4: framing, 12 words -> tlast on 4 and 9, two frame_done pulses
        do_reset(1);
        obs_d.delete(); obs_l.delete();
        fd0 = fd_count;
        for (int i = 0; i < 12; i++) push_word(40'(i + 1) << 8);
        drain();
        chk("t4_count", obs_d.size(), 12);
        for (int i = 0; i < 12; i++) chk_obs("t4", i, 16'(i + 1), (i == 4) || (i == 9));
        chk("t4_frame_done_pulses", fd_count - fd0, 2);
        // counter sits at 2: three more words end the frame
        obs_d.delete(); obs_l.delete();
        for (int i = 0; i < 3; i++) push_word(40'(i + 50) << 8);
        drain();
        chk_obs("t4b", 0, 16'd50, 1'b0);
        chk_obs("t4b", 1, 16'd51, 1'b0);
        chk_obs("t4b", 2, 16'd52, 1'b1);

        // 5: random valid/ready, 10k words against the model
        sent = 0;
        cyc = 0;
        res_data = 40'h12345;
        while (sent < 10000 && cyc < 60000) begin
            res_valid = 1'($urandom_range(0, 1));
            tready = 1'($urandom_range(0, 1));
            @(negedge aclk);
            nxt = res_valid && res_ready;
            if (nxt) sent++;
            @(posedge aclk);
            #1;
            cyc++;
            if (nxt) begin
                r32 = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    x = {r32[7:0], 32'($urandom)};
                end else begin
                    si = int'(r32) >>> $urandom_range(8, 24);
                    x = 40'(si);
                end
                res_data = x;
            end
        end
        res_valid = 1'b0;
        drain();
        chk("t5_sent", sent, 10000);
        chk("t5_model_empty", exp_q.size(), 0);

        // 6: reset with 7 words buffered mid-frame
        do_reset(1);
        push_word(40'h200);
        push_word(40'h300);
        drain();
        tready = 1'b0;
        for (int i = 0; i < 7; i++) push_word(40'(i + 10) << 8);
        do_reset(1);
        @(negedge aclk);
        chk("t6_tvalid_after_rst", tvalid, 0);
        chk("t6_busy_after_rst", busy, 0);
        step();
        tready = 1'b1;
        obs_d.delete(); obs_l.delete();
        for (int i = 0; i < 5; i++) push_word(40'(i + 30) << 8);
        drain();
        chk("t6_count", obs_d.size(), 5);
        for (int i = 0; i < 5; i++) chk_obs("t6", i, 16'(i + 30), i == 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
